if_stage: RTL

- Instruction-fetch stage of the 5-stage LoongArch32 pipeline; the producer end of the IF->ID interface.
- Generates the PC and fetches from instruction SRAM using a req/addr_ok/data_ok handshake.
- Holds at most one fetched instruction and delivers {pc, inst} to ID under the valid/allow handshake.
- Consumes ID's {br_taken, br_target} redirect.

---
 rtl/if_pkg.sv | 29 ++
 rtl/if_inst_buf.sv | 35 +++
 rtl/if_stage.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/if_pkg.sv
// Shared types and constants for the LoongArch32 instruction-fetch stage.
// Bundle layouts: IF->ID is {pc, inst}, ID->IF is {br_taken, br_target}.
package if_pkg;

  localparam int          IF_TO_ID_W       = 64;
  localparam int          ID_TO_IF_W       = 33;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h1c00_0000;

  localparam int BR_TAKEN_BIT  = 32;
  localparam int BR_TARGET_LSB = 0;
  localparam int BUS_PC_LSB    = 32;
  localparam int BUS_INST_LSB  = 0;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } if_state_e;

  function automatic logic [IF_TO_ID_W-1:0] pack_if_to_id(input logic [31:0] pc,
                                                           input logic [31:0] inst);
    logic [IF_TO_ID_W-1:0] bus;
    bus = {IF_TO_ID_W{1'b0}};
    bus[BUS_PC_LSB +: 32]   = pc;
    bus[BUS_INST_LSB +: 32] = inst;
    return bus;
  endfunction

endpackage

// File: rtl/if_inst_buf.sv
// One-entry {pc, inst} holding register between the fetch FSM and ID.
// Clear wins over load; data is left untouched on clear so it only changes on a new load.
module if_inst_buf
  import if_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic                  clear,
  input  logic [31:0]           load_pc,
  input  logic [31:0]           load_inst,
  output logic                  valid,
  output logic [IF_TO_ID_W-1:0] data
);

  logic                  valid_r;
  logic [IF_TO_ID_W-1:0] data_r;

  // Entry valid flag and payload.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_r <= 1'b0;
      data_r  <= {IF_TO_ID_W{1'b0}};
    end else if (clear) begin
      valid_r <= 1'b0;
    end else if (load) begin
      valid_r <= 1'b1;
      data_r  <= pack_if_to_id(load_pc, load_inst);
    end
  end

  assign valid = valid_r;
  assign data  = data_r;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC generation, single-outstanding SRAM fetch, IF->ID handoff.
// Optional macro IF_PERF_CNT_EN adds perf_fetch_cnt / perf_cancel_cnt outputs.
module if_stage
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
)
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  id_allow,
  output logic                  if_to_id_valid,
  output logic [IF_TO_ID_W-1:0] if_to_id_data,
  input  logic [ID_TO_IF_W-1:0] id_to_if_data,
  output logic                  inst_sram_req,
  output logic [31:0]           inst_sram_addr,
  input  logic                  inst_sram_addr_ok,
  input  logic                  inst_sram_data_ok,
  input  logic [31:0]           inst_sram_rdata
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]           perf_fetch_cnt,
  output logic [31:0]           perf_cancel_cnt
`endif
);

  if_state_e   state_r, state_s;
  logic [31:0] fetch_pc_r, fetch_pc_s;
  logic        cancel_r, cancel_s;
  logic        req_r;
  logic        buf_load_s, buf_clear_s, buf_valid_s;
  logic        fetch_inc_s, cancel_inc_s;
  logic        br_taken_s;
  logic [31:0] br_target_s;

  assign br_taken_s  = id_to_if_data[BR_TAKEN_BIT];
  assign br_target_s = id_to_if_data[BR_TARGET_LSB +: 32];

  // FSM state, fetch PC, cancel flag and the registered request strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= S_REQ;
      fetch_pc_r <= RESET_PC;
      cancel_r   <= 1'b0;
      req_r      <= 1'b1;
    end else begin
      state_r    <= state_s;
      fetch_pc_r <= fetch_pc_s;
      cancel_r   <= cancel_s;
      req_r      <= (state_s == S_REQ);
    end
  end

  // Next-state logic; a redirect overrides every other event in the same cycle.
  always_comb begin
    state_s      = state_r;
    fetch_pc_s   = fetch_pc_r;
    cancel_s     = cancel_r;
    buf_load_s   = 1'b0;
    buf_clear_s  = 1'b0;
    fetch_inc_s  = 1'b0;
    cancel_inc_s = 1'b0;
    case (state_r)
      S_REQ: begin
        if (inst_sram_addr_ok) begin
          state_s  = S_WAIT;
          cancel_s = br_taken_s;
        end else begin
          state_s  = S_REQ;
        end
        if (br_taken_s) begin
          fetch_pc_s = br_target_s;
        end else begin
          fetch_pc_s = fetch_pc_r;
        end
      end
      S_WAIT: begin
        if (br_taken_s) begin
          fetch_pc_s = br_target_s;
        end else begin
          fetch_pc_s = fetch_pc_r;
        end
        if (inst_sram_data_ok) begin
          if (cancel_r || br_taken_s) begin
            state_s      = S_REQ;
            cancel_s     = 1'b0;
            cancel_inc_s = 1'b1;
          end else begin
            state_s    = S_HOLD;
            buf_load_s = 1'b1;
          end
        end else if (br_taken_s) begin
          cancel_s = 1'b1;
        end else begin
          cancel_s = cancel_r;
        end
      end
      S_HOLD: begin
        if (br_taken_s) begin
          state_s      = S_REQ;
          fetch_pc_s   = br_target_s;
          buf_clear_s  = 1'b1;
          cancel_inc_s = buf_valid_s;
        end else if (buf_valid_s && id_allow) begin
          state_s     = S_REQ;
          fetch_pc_s  = fetch_pc_r + 32'd4;
          buf_clear_s = 1'b1;
          fetch_inc_s = 1'b1;
        end else begin
          state_s = S_HOLD;
        end
      end
      default: begin
        state_s = S_REQ;
      end
    endcase
  end

  if_inst_buf u_inst_buf (
    .clk       (clk),
    .reset     (reset),
    .load      (buf_load_s),
    .clear     (buf_clear_s),
    .load_pc   (fetch_pc_r),
    .load_inst (inst_sram_rdata),
    .valid     (buf_valid_s),
    .data      (if_to_id_data)
  );

  assign if_to_id_valid = buf_valid_s;
  assign inst_sram_req  = req_r;
  assign inst_sram_addr = fetch_pc_r;

`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetch_r, perf_cancel_r;

  // Transfer and discard event counters, free-running with wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_fetch_r  <= 32'd0;
      perf_cancel_r <= 32'd0;
    end else begin
      if (fetch_inc_s) begin
        perf_fetch_r <= perf_fetch_r + 32'd1;
      end
      if (cancel_inc_s) begin
        perf_cancel_r <= perf_cancel_r + 32'd1;
      end
    end
  end

  assign perf_fetch_cnt  = perf_fetch_r;
  assign perf_cancel_cnt = perf_cancel_r;
`else
  logic unused_inc_s;
  assign unused_inc_s = fetch_inc_s ^ cancel_inc_s;
`endif

endmodule
